// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// UART_ARB_BURST_EN enables multi-byte grants (see uart_tx_arbiter).
package uart_tx_arbiter_pkg;

  localparam int DATA_W_DEF = 8;

`ifdef UART_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } arb_state_t;

  // Bits needed to count up to (timeout - 1) cycles since tx_enable.
  function automatic int cnt_width(input int timeout);
    return ($clog2(timeout) < 1) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Rotate-priority selector: first set request after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW:0]          base;
  logic [IW:0]          sum;
  logic [IW-1:0]        off;

  // rot[k] is request (ptr+1+k) mod NUM_REQ
  always_comb begin
    dbl  = {req, req};
    base = {1'b0, ptr} + (IW+1)'(1);
    rot  = dbl[base +: NUM_REQ];
    off  = '0;
    any  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IW'(k);
        any = 1'b1;
      end
    end
    sum = base + {1'b0, off};
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    idx = sum[IW-1:0];
    gnt = '0;
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ producers.
// Define UART_ARB_BURST_EN to allow up to BURST_LEN bytes per grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int INPUT_DATA_WIDTH = DATA_W_DEF,
  parameter int BUSY_TIMEOUT     = 16,
  parameter int BURST_LEN        = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  tx_enable,
  output logic [INPUT_DATA_WIDTH-1:0]           tx_data,
  input  logic                                  tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id,
  output logic                                  arb_busy,
  output logic                                  timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(BUSY_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam int BURST_MAX =
    (BURST_EN && BURST_LEN > 1) ? BURST_LEN : 1;
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_TOP = BW'(BURST_MAX);

  arb_state_t state_q, state_d;

  logic [IW-1:0]               ptr_q;
  logic [NUM_REQ-1:0]          grant_oh_q;
  logic [CW-1:0]               cnt_q;
  logic [BW-1:0]               burst_q;
  logic [INPUT_DATA_WIDTH-1:0] req_byte [NUM_REQ];
  logic [NUM_REQ-1:0]          win_oh;
  logic [IW-1:0]               win_idx;
  logic [IW-1:0]               sel_idx;
  logic                        win_any;
  logic                        new_grant;
  logic                        reissue;
  logic                        timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = req_data[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    new_grant = 1'b0;
    reissue   = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!tx_busy && win_any) begin
          state_d   = S_ISSUE;
          new_grant = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          // Burst continuation skips the idle cycle and arbitration
          if (req_valid[grant_id] && burst_q < BURST_TOP) begin
            state_d = S_ISSUE;
            reissue = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sel_idx = new_grant ? win_idx : grant_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      grant_id    <= '0;
      grant_oh_q  <= '0;
      tx_data     <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (new_grant || reissue) begin
        tx_data <= req_byte[sel_idx];
      end
      if (new_grant) begin
        grant_id   <= win_idx;
        grant_oh_q <= win_oh;
        ptr_q      <= win_idx;
        burst_q    <= BW'(1);
      end else if (reissue) begin
        burst_q <= burst_q + BW'(1);
      end
      // cnt_q tracks cycles elapsed since tx_enable
      if (state_q == S_ISSUE) begin
        cnt_q <= CW'(1);
      end else if (state_q == S_WAIT_BUSY && cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_ISSUE) begin
      req_ready = grant_oh_q;
    end
  end

  assign tx_enable = (state_q == S_ISSUE);
  assign arb_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART busy model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NV = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_enable;
  logic [W-1:0]   tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           arb_busy;
  logic           timeout_err;

  logic model_busy;
  logic busy_force;
  logic no_busy;
  int   u_t = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   viol = 0;

  assign tx_busy = model_busy | busy_force;

  uart_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // UART: busy one cycle after enable, for 10 cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u_t        <= 0;
      model_busy <= 1'b0;
    end else begin
      if (tx_enable && !no_busy) u_t <= 1;
      else if (u_t == 11)        u_t <= 0;
      else if (u_t != 0)         u_t <= u_t + 1;
      model_busy <= (u_t >= 1) && (u_t <= 10);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_enable && tx_busy)          viol++;
      if (!$onehot0(req_ready))          viol++;
      if (tx_enable != (|req_ready))     viol++;
    end
  end

  typedef struct {
    logic [N-1:0] mask;
    int           exp;
  } vec_t;

  vec_t vt[NV];
  int   got[6];
  int   exp6[6];

  task automatic check(input string nm, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [7:0] data_of(input int i, input int n);
    return 8'(((i & 15) << 4) | (n & 15));
  endfunction

  function automatic int oh2idx(input logic [N-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic drive(input logic [N-1:0] m, input int n);
    req_valid = m;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = data_of(i, n);
  endtask

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (|req_ready) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (!arb_busy) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    int bad, extra, first, got_n;
    bit saw;

    vt[0]  = '{4'hF, 0}; vt[1]  = '{4'hF, 1};
    vt[2]  = '{4'hF, 2}; vt[3]  = '{4'hF, 3};
    vt[4]  = '{4'hF, 0}; vt[5]  = '{4'hF, 1};
    vt[6]  = '{4'hF, 2}; vt[7]  = '{4'hF, 3};
    vt[8]  = '{4'h4, 2}; vt[9]  = '{4'hA, 3};
    vt[10] = '{4'h3, 0}; vt[11] = '{4'h6, 1};
    vt[12] = '{4'h1, 0}; vt[13] = '{4'h8, 3};
    vt[14] = '{4'h9, 0}; vt[15] = '{4'hC, 2};
`ifdef UART_ARB_BURST_EN
    exp6 = '{0, 0, 0, 0, 1, 1};
`else
    exp6 = '{0, 1, 0, 1, 0, 1};
`endif

    reset      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    busy_force = 1'b0;
    no_busy    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", 0,
          {req_ready, tx_enable, tx_data, grant_id, arb_busy, timeout_err}, 0);
    reset = 1'b0;

    // Single byte from requester 0
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA5;
    @(negedge clk);
    check("t1_ready", 0, req_ready, 1);
    check("t1_enable", 0, tx_enable, 1);
    check("t1_data", 0, tx_data, 8'hA5);
    check("t1_grant", 0, grant_id, 0);
    req_valid = '0;
    bad = 0; extra = 0; saw = 1'b0; ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (tx_data != 8'hA5) bad++;
      if (|req_ready) extra++;
      if (tx_busy) saw = 1'b1;
      if (!arb_busy) ok = 1'b1;
    end
    check("t1_idle", 0, ok, 1);
    check("t1_hold", 0, bad, 0);
    check("t1_extra_ready", 0, extra, 0);
    check("t1_saw_busy", 0, saw, 1);

    // UART never answers: timeout after exactly 16 cycles
    no_busy = 1'b1;
    drive(4'b0010, 1);
    wait_ready(20, ok);
    check("t4_ready", 0, req_ready, 4'b0010);
    req_valid = '0;
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(negedge clk);
      if (timeout_err) first = k;
    end
    check("t4_timeout_cycle", 0, first, 16);
    check("t4_idle", 0, arb_busy, 0);
    no_busy = 1'b0;
    drive(4'b0100, 2);
    wait_ready(20, ok);
    check("t4_next_ready", 0, req_ready, 4'b0100);
    check("t4_next_data", 0, tx_data, data_of(2, 2));
    req_valid = '0;
    wait_idle(40, ok);
    check("t4_sticky", 0, timeout_err, 1);

    // Async reset in WAIT_DONE
    drive(4'b1000, 3);
    wait_ready(20, ok);
    check("t5_ready", 0, req_ready, 4'b1000);
    req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
    check("t5_busy_seen", 0, ok, 1);
    @(negedge clk);
    check("t5_in_done", 0, arb_busy, 1);
    reset = 1'b1;
    #1;
    check("t5_async_zero", 0,
          {req_ready, tx_enable, tx_data, grant_id, arb_busy, timeout_err}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Arbitration table
    for (int v = 0; v < NV; v++) begin
      drive(vt[v].mask, v);
      wait_ready(20, ok);
      check("vec_seen", v, ok, 1);
      check("vec_ready", v, req_ready, 32'(1) << vt[v].exp);
      check("vec_grant", v, grant_id, vt[v].exp);
      check("vec_data", v, tx_data, data_of(vt[v].exp, v));
      req_valid = '0;
      wait_idle(40, ok);
      check("vec_idle", v, ok, 1);
    end

    // UART busy while idle: hold off until it clears
    busy_force = 1'b1;
    drive(4'b0010, 5);
    extra = 0; bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (|req_ready || tx_enable) extra++;
      if (arb_busy) bad++;
    end
    check("idlebusy_no_issue", 0, extra, 0);
    check("idlebusy_stay_idle", 0, bad, 0);
    busy_force = 1'b0;
    wait_ready(20, ok);
    check("idlebusy_ready", 0, req_ready, 4'b0010);
    req_valid = '0;
    wait_idle(40, ok);

    // Two requesters holding valid: grant pattern
    do_reset();
    for (int k = 0; k < 6; k++) got[k] = -1;
    drive(4'b0011, 6);
    got_n = 0;
    for (int c = 0; c < 300 && got_n < 6; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        got[got_n] = oh2idx(req_ready);
        got_n++;
      end
    end
    req_valid = '0;
    check("t6_count", 0, got_n, 6);
    for (int k = 0; k < 6; k++) check("t6_order", k, got[k], exp6[k]);
    wait_idle(40, ok);
    check("t6_idle", 0, ok, 1);

    check("protocol_viol", 0, viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
